// File: rtl/read_handler_tmr.sv
// Read-side pointer and empty-flag handler for an asynchronous FIFO.
// Three state replicas are majority-voted and scrubbed every cycle.
module read_handler_tmr #(
  parameter int unsigned ADDRESS_SIZE    = 5,
  parameter int unsigned ERR_COUNT_WIDTH = 8
) (
  input  logic                       read_clock,
  input  logic                       reset,
  input  logic                       read_enable,
  input  logic [ADDRESS_SIZE:0]      synch_wrpointer,
  input  logic [2:0]                 seu_inject,
  output logic [ADDRESS_SIZE-1:0]    read_address,
  output logic [ADDRESS_SIZE:0]      read_pointer,
  output logic                       read_empty,
  output logic                       tmr_error,
  output logic [ERR_COUNT_WIDTH-1:0] tmr_error_count
);

  localparam int unsigned PtrW = ADDRESS_SIZE + 1;

  logic [PtrW-1:0] bin_q  [3];
  logic [PtrW-1:0] gray_q [3];
  logic [2:0]      empty_q;

  logic [PtrW-1:0] vbin, vgray;
  logic            vempty;
  logic            pop;
  logic [PtrW-1:0] bin_next, gray_next;
  logic            empty_next;
  logic            mismatch;

  // Bitwise 2-of-3 majority.
  assign vbin   = (bin_q[0] & bin_q[1]) | (bin_q[0] & bin_q[2]) | (bin_q[1] & bin_q[2]);
  assign vgray  = (gray_q[0] & gray_q[1]) | (gray_q[0] & gray_q[2]) | (gray_q[1] & gray_q[2]);
  assign vempty = (empty_q[0] & empty_q[1]) | (empty_q[0] & empty_q[2]) |
                  (empty_q[1] & empty_q[2]);

  assign read_address = vbin[ADDRESS_SIZE-1:0];
  assign read_pointer = vgray;
  assign read_empty   = vempty;

  assign pop        = read_enable & ~vempty;
  assign bin_next   = vbin + {{ADDRESS_SIZE{1'b0}}, pop};
  assign gray_next  = (bin_next >> 1) ^ bin_next;
  assign empty_next = (gray_next == synch_wrpointer);

  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ((bin_q[i] != vbin) || (gray_q[i] != vgray) || (empty_q[i] != vempty)) begin
        mismatch = 1'b1;
      end
    end
  end

  // Every replica reloads from the voted next state, which scrubs a single upset.
  always_ff @(posedge read_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        bin_q[i]  <= '0;
        gray_q[i] <= '0;
      end
      empty_q         <= 3'b111;
      tmr_error       <= 1'b0;
      tmr_error_count <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        bin_q[i]  <= bin_next ^ {{ADDRESS_SIZE{1'b0}}, seu_inject[i]};
        gray_q[i] <= gray_next;
      end
      empty_q   <= {3{empty_next}};
      tmr_error <= mismatch;
      if (mismatch && (tmr_error_count != '1)) begin
        tmr_error_count <= tmr_error_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_read_handler_tmr.sv
// Directed bench for read_handler_tmr: reset, empty tracking, wrap, SEU scrubbing, saturation.
module tb_read_handler_tmr;

  logic       clk = 1'b0;
  logic       reset;
  logic       read_enable;
  logic [5:0] synch_wrpointer;
  logic [2:0] seu_inject;
  logic [4:0] read_address;
  logic [5:0] read_pointer;
  logic       read_empty;
  logic       tmr_error;
  logic [7:0] tmr_error_count;

  int total = 0;
  int bad   = 0;

  read_handler_tmr #(
    .ADDRESS_SIZE   (5),
    .ERR_COUNT_WIDTH(8)
  ) dut (
    .read_clock     (clk),
    .reset          (reset),
    .read_enable    (read_enable),
    .synch_wrpointer(synch_wrpointer),
    .seu_inject     (seu_inject),
    .read_address   (read_address),
    .read_pointer   (read_pointer),
    .read_empty     (read_empty),
    .tmr_error      (tmr_error),
    .tmr_error_count(tmr_error_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] to_gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    read_enable     = 1'b0;
    seu_inject      = 3'b000;
    synch_wrpointer = 6'b000000;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (read_address !== 5'd0) begin bad++;
      $display("FAIL reset_addr got=%0d want=0", read_address); end
    total++; if (read_pointer !== 6'b000000) begin bad++;
      $display("FAIL reset_ptr got=%b want=000000", read_pointer); end
    total++; if (read_empty !== 1'b1) begin bad++;
      $display("FAIL reset_empty got=%b want=1", read_empty); end
    total++; if (tmr_error !== 1'b0) begin bad++;
      $display("FAIL reset_err got=%b want=0", tmr_error); end
    total++; if (tmr_error_count !== 8'd0) begin bad++;
      $display("FAIL reset_cnt got=%0d want=0", tmr_error_count); end
  endtask

  task automatic test_empty();
    logic [4:0] exp_addr [4];
    logic       exp_emp  [4];
    exp_addr = '{5'd1, 5'd2, 5'd3, 5'd3};
    exp_emp  = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    synch_wrpointer = 6'b000010;
    total++; if (read_empty !== 1'b1) begin bad++;
      $display("FAIL empty_before_edge got=%b want=1", read_empty); end
    tick();
    total++; if (read_empty !== 1'b0) begin bad++;
      $display("FAIL empty_after_write got=%b want=0", read_empty); end
    read_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (read_address !== exp_addr[i]) begin bad++;
        $display("FAIL pop_addr[%0d] got=%0d want=%0d", i, read_address, exp_addr[i]); end
      total++; if (read_empty !== exp_emp[i]) begin bad++;
        $display("FAIL pop_empty[%0d] got=%b want=%b", i, read_empty, exp_emp[i]); end
    end
    read_enable = 1'b0;
    total++; if (read_pointer !== to_gray(6'd3)) begin bad++;
      $display("FAIL underflow_ptr got=%b want=%b", read_pointer, to_gray(6'd3)); end
  endtask

  task automatic test_wrap();
    logic [5:0] b;
    do_reset();
    b = 6'd0;
    synch_wrpointer = to_gray(6'd3);
    tick();
    read_enable = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      synch_wrpointer = to_gray(b + 6'd3);
      tick();
      b = b + 6'd1;
      total++; if (read_pointer !== to_gray(b)) begin bad++;
        $display("FAIL wrap_ptr[%0d] got=%b want=%b", i, read_pointer, to_gray(b)); end
      if (i == 32) begin
        total++; if (read_address !== 5'd0) begin bad++;
          $display("FAIL wrap32_addr got=%0d want=0", read_address); end
        total++; if (read_pointer !== 6'b110000) begin bad++;
          $display("FAIL wrap32_ptr got=%b want=110000", read_pointer); end
      end
    end
    read_enable = 1'b0;
    total++; if (read_pointer !== 6'b000000) begin bad++;
      $display("FAIL wrap64_ptr got=%b want=000000", read_pointer); end
  endtask

  task automatic test_single_seu();
    logic [2:0] pat [2];
    pat = '{3'b010, 3'b001};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      seu_inject = pat[k];
      tick();
      seu_inject = 3'b000;
      total++; if ({read_address, read_pointer, read_empty} !== {5'd0, 6'd0, 1'b1}) begin bad++;
        $display("FAIL seu%0d_outputs got=%0d/%b/%b want=0/000000/1", k, read_address,
                 read_pointer, read_empty); end
      total++; if (tmr_error !== 1'b0) begin bad++;
        $display("FAIL seu%0d_err_early got=%b want=0", k, tmr_error); end
      tick();
      total++; if (tmr_error !== 1'b1) begin bad++;
        $display("FAIL seu%0d_err_pulse got=%b want=1", k, tmr_error); end
      total++; if (tmr_error_count !== 8'(k + 1)) begin bad++;
        $display("FAIL seu%0d_cnt got=%0d want=%0d", k, tmr_error_count, k + 1); end
      tick();
      total++; if (tmr_error !== 1'b0) begin bad++;
        $display("FAIL seu%0d_err_clear got=%b want=0", k, tmr_error); end
      total++; if (read_address !== 5'd0) begin bad++;
        $display("FAIL seu%0d_addr got=%0d want=0", k, read_address); end
    end
  endtask

  task automatic test_double_seu();
    do_reset();
    synch_wrpointer = to_gray(6'd6);
    tick();
    read_enable = 1'b1;
    repeat (4) tick();
    read_enable = 1'b0;
    total++; if (read_address !== 5'd4) begin bad++;
      $display("FAIL dbl_setup_addr got=%0d want=4", read_address); end
    seu_inject = 3'b011;
    tick();
    seu_inject = 3'b000;
    total++; if (read_address !== 5'd5) begin bad++;
      $display("FAIL dbl_addr got=%0d want=5", read_address); end
    tick();
    total++; if (tmr_error !== 1'b1 || tmr_error_count !== 8'd1) begin bad++;
      $display("FAIL dbl_err got=%b/%0d want=1/1", tmr_error, tmr_error_count); end
    tick();
    total++; if (tmr_error !== 1'b0 || read_address !== 5'd5 || tmr_error_count !== 8'd1) begin
      bad++;
      $display("FAIL dbl_scrubbed got=%b/%0d/%0d want=0/5/1", tmr_error, read_address,
               tmr_error_count); end
    // Pop together with an identical upset in all replicas: 5+1 then bit0 flipped.
    read_enable = 1'b1;
    seu_inject  = 3'b111;
    tick();
    read_enable = 1'b0;
    seu_inject  = 3'b000;
    total++; if (read_address !== 5'd7) begin bad++;
      $display("FAIL triple_addr got=%0d want=7", read_address); end
    tick();
    total++; if (tmr_error !== 1'b0 || tmr_error_count !== 8'd1) begin bad++;
      $display("FAIL triple_undetected got=%b/%0d want=0/1", tmr_error, tmr_error_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 255; i++) begin
      seu_inject = 3'b001;
      tick();
      seu_inject = 3'b000;
      tick();
      if (i == 253) begin
        total++; if (tmr_error_count !== 8'hFE) begin bad++;
          $display("FAIL sat_254 got=%h want=fe", tmr_error_count); end
      end
    end
    total++; if (tmr_error_count !== 8'hFF) begin bad++;
      $display("FAIL sat_255 got=%h want=ff", tmr_error_count); end
    seu_inject = 3'b100;
    tick();
    seu_inject = 3'b000;
    tick();
    total++; if (tmr_error !== 1'b1 || tmr_error_count !== 8'hFF) begin bad++;
      $display("FAIL sat_hold got=%b/%h want=1/ff", tmr_error, tmr_error_count); end
  endtask

  task automatic test_async_reset();
    seu_inject = 3'b011;
    tick();
    seu_inject = 3'b000;
    tick();
    total++; if (read_address !== 5'd1 || tmr_error !== 1'b1) begin bad++;
      $display("FAIL areset_setup got=%0d/%b want=1/1", read_address, tmr_error); end
    #2;
    reset = 1'b0;
    #1;
    total++; if ({read_address, read_pointer, read_empty, tmr_error, tmr_error_count}
                 !== {5'd0, 6'd0, 1'b1, 1'b0, 8'd0}) begin bad++;
      $display("FAIL areset_outputs got=%0d/%b/%b/%b/%0d want=0/000000/1/0/0", read_address,
               read_pointer, read_empty, tmr_error, tmr_error_count); end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_empty();
    test_wrap();
    test_single_seu();
    test_double_seu();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
